// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Items shared by the ADC result averager and its sub-block:
//   ADC_DATA_W      - width of an ADC logic B conversion word
//   AVG_LOG2_MIN/MAX - legal range for the log2 frame length
//   avg_state_e     - averager control states
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_DATA_W   = 10;
  localparam int AVG_LOG2_MIN = 0;
  localparam int AVG_LOG2_MAX = 4;

  // IDLE  : averaging disabled, sample counter held at zero
  // ACCUM : collecting samples, no result waiting downstream
  // PEND  : collecting samples while a result waits on out_valid
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PEND  = 2'd2
  } avg_state_e;

endpackage

// File: rtl/adc_eoc_edge.sv
// ---------------------------------------------------------------------------
// adc_eoc_edge
// Registered rising-edge detector for the ADC end-of-conversion level.
// A level held high yields one strobe. A level that is already high when
// reset releases is ignored until it has been seen low.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   eoc    - end-of-conversion level
//   enable - gates the strobe
//   strobe - one-cycle pulse on a qualified 0->1 transition of eoc
// ---------------------------------------------------------------------------
module adc_eoc_edge (
  input  logic clk,
  input  logic rst,
  input  logic eoc,
  input  logic enable,
  output logic strobe
);

  logic eoc_q;
  logic blocked;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      eoc_q   <= 1'b0;
      // Arm only if eoc is low on the final reset edge; otherwise wait for
      // it to fall first so a stale conversion is not counted.
      blocked <= eoc;
    end else begin
      eoc_q <= eoc;
      if (!eoc) begin
        blocked <= 1'b0;
      end
    end
  end

  assign strobe = eoc & ~eoc_q & ~blocked & enable;

endmodule

// File: rtl/adc_result_averager.sv
// ---------------------------------------------------------------------------
// adc_result_averager
// Collects frames of 2**AVG_LOG2 ADC conversions and presents the truncated
// mean, minimum and maximum through a valid/ready output. A frame finishing
// while the previous result is still unaccepted is dropped and recorded in
// the sticky overrun flag (cleared while enable is low).
//   wb_clk_i  - clock, rising edge
//   wb_rst_i  - synchronous active-high reset
//   enable    - 1 = averaging active, 0 = discard partial frame
//   eoc       - end-of-conversion level; a 0->1 transition is one sample
//   b_in      - conversion result, stable while eoc is high
//   out_ready - downstream accepts when out_valid & out_ready
//   out_valid - a frame result is presented
//   avg_out   - frame mean, truncated
//   min_out   - smallest sample of the frame
//   max_out   - largest sample of the frame
//   overrun   - sticky: at least one completed frame was dropped
// ---------------------------------------------------------------------------
module adc_result_averager
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic              eoc,
  input  logic [DATA_W-1:0] b_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] avg_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out,
  output logic              overrun
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(1) << AVG_LOG2;

  if (AVG_LOG2 < AVG_LOG2_MIN || AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_avg_log2
    $error("adc_result_averager: AVG_LOG2 out of legal range");
  end

  logic strobe;

  adc_eoc_edge u_eoc_edge (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .eoc    (eoc),
    .enable (enable),
    .strobe (strobe)
  );

  avg_state_e        state;
  avg_state_e        state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] min_next;
  logic [DATA_W-1:0] max_next;
  logic [DATA_W-1:0] avg_calc;
  logic              first;
  logic              frame_done;
  logic              handshake;
  logic              load_result;
  logic              drop_result;

  // Datapath: values the accumulator/min/max take if this edge captures,
  // which for the last sample of a frame are also the frame result.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    cnt_inc    = count + CNT_W'(1);
    first      = (count == '0);
    frame_done = strobe && (cnt_inc == FRAME_LEN);
    handshake  = out_valid && out_ready;

    acc_next = first ? ACC_W'(b_in) : acc + ACC_W'(b_in);
    min_next = (first || (b_in < min_q)) ? b_in : min_q;
    max_next = (first || (b_in > max_q)) ? b_in : max_q;
    avg_calc = DATA_W'(acc_next >> AVG_LOG2);

    // A finished frame may only replace the held result if that result is
    // absent or being accepted on this very edge.
    load_result = frame_done && (!out_valid || handshake);
    drop_result = frame_done && out_valid && !handshake;
  end

  // Control FSM: PEND tracks a result sitting on out_valid while enabled.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // A result left pending across a disable period keeps its PEND
          // status when averaging resumes.
          if (load_result || (out_valid && !handshake)) begin
            state_next = PEND;
          end else begin
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          if (frame_done) begin
            state_next = PEND;
          end
        end
        PEND: begin
          if (handshake && !frame_done) begin
            state_next = ACCUM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      min_q     <= '0;
      max_q     <= '0;
      out_valid <= 1'b0;
      avg_out   <= '0;
      min_out   <= '0;
      max_out   <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;

      // Counter restarts on the completing edge so a back-to-back strobe
      // becomes the first sample of the next frame.
      if (!enable) begin
        count <= '0;
      end else if (strobe) begin
        count <= frame_done ? '0 : cnt_inc;
      end

      if (strobe) begin
        acc   <= acc_next;
        min_q <= min_next;
        max_q <= max_next;
      end

      if (load_result) begin
        out_valid <= 1'b1;
        avg_out   <= avg_calc;
        min_out   <= min_next;
        max_out   <= max_next;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (!enable) begin
        overrun <= 1'b0;
      end else if (drop_result) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_result_averager.sv
// ---------------------------------------------------------------------------
// tb_adc_result_averager
// Directed bench for adc_result_averager. dut uses AVG_LOG2=2 (frames of
// four); dut0 shares the inputs with AVG_LOG2=0 (every sample is a frame).
// ---------------------------------------------------------------------------
module tb_adc_result_averager;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          eoc;
  logic [DW-1:0] b_in;
  logic          out_ready;

  logic          out_valid;
  logic [DW-1:0] avg_out;
  logic [DW-1:0] min_out;
  logic [DW-1:0] max_out;
  logic          overrun;

  logic          out_valid0;
  logic [DW-1:0] avg_out0;
  logic [DW-1:0] min_out0;
  logic [DW-1:0] max_out0;
  logic          overrun0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_result_averager #(.DATA_W(DW), .AVG_LOG2(2)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .enable    (enable),
    .eoc       (eoc),
    .b_in      (b_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .avg_out   (avg_out),
    .min_out   (min_out),
    .max_out   (max_out),
    .overrun   (overrun)
  );

  adc_result_averager #(.DATA_W(DW), .AVG_LOG2(0)) dut0 (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .enable    (enable),
    .eoc       (eoc),
    .b_in      (b_in),
    .out_ready (out_ready),
    .out_valid (out_valid0),
    .avg_out   (avg_out0),
    .min_out   (min_out0),
    .max_out   (max_out0),
    .overrun   (overrun0)
  );

  typedef struct {
    logic [DW-1:0] s0, s1, s2, s3;
    logic [DW-1:0] exp_avg, exp_min, exp_max;
  } frame_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete conversion: eoc high for one edge (capture), then low.
  task automatic pulse(input logic [DW-1:0] v);
    b_in = v;
    eoc  = 1'b1;
    tick();
    eoc = 1'b0;
    tick();
  endtask

  // Capture edge only; caller inspects outputs before the next tick.
  task automatic last_sample(input logic [DW-1:0] v);
    b_in = v;
    eoc  = 1'b1;
    tick();
    eoc = 1'b0;
  endtask

  frame_vec_t vecs[6];

  initial begin
    vecs[0] = '{s0: 100,  s1: 104, s2: 108,  s3: 112, exp_avg: 106,  exp_min: 100, exp_max: 112};
    vecs[1] = '{s0: 1023, s1: 1023, s2: 1023, s3: 1023, exp_avg: 1023, exp_min: 1023, exp_max: 1023};
    vecs[2] = '{s0: 0,    s1: 1,   s2: 1,    s3: 1,   exp_avg: 0,    exp_min: 0,   exp_max: 1};
    vecs[3] = '{s0: 7,    s1: 3,   s2: 9,    s3: 5,   exp_avg: 6,    exp_min: 3,   exp_max: 9};
    vecs[4] = '{s0: 512,  s1: 0,   s2: 1023, s3: 256, exp_avg: 447,  exp_min: 0,   exp_max: 1023};
    vecs[5] = '{s0: 10,   s1: 11,  s2: 10,   s3: 11,  exp_avg: 10,   exp_min: 10,  exp_max: 11};

    // Reset with eoc already high: must not count once reset releases.
    rst       = 1'b1;
    enable    = 1'b1;
    eoc       = 1'b1;
    b_in      = 900;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",   out_valid, 0);
    check("rst_avg",     avg_out,   0);
    check("rst_min",     min_out,   0);
    check("rst_max",     max_out,   0);
    check("rst_overrun", overrun,   0);
    check("rst_valid0",  out_valid0, 0);

    rst = 1'b0;
    repeat (3) tick();
    check("eoc_high_at_release_valid", out_valid, 0);
    eoc = 1'b0;
    tick();
    pulse(20); pulse(20); pulse(20);
    check("rel_three_samples_valid", out_valid, 0);
    last_sample(20);
    check("rel_frame_valid", out_valid, 1);
    check("rel_frame_avg",   avg_out,   20);
    tick();

    // Table-driven frames with out_ready=1.
    for (int i = 0; i < 6; i++) begin
      pulse(vecs[i].s0);
      pulse(vecs[i].s1);
      pulse(vecs[i].s2);
      check($sformatf("v%0d_pre_valid", i), out_valid, 0);
      last_sample(vecs[i].s3);
      check($sformatf("v%0d_valid", i), out_valid, 1);
      check($sformatf("v%0d_avg", i),   avg_out,   vecs[i].exp_avg);
      check($sformatf("v%0d_min", i),   min_out,   vecs[i].exp_min);
      check($sformatf("v%0d_max", i),   max_out,   vecs[i].exp_max);
      check($sformatf("v%0d_valid0", i), out_valid0, 1);
      check($sformatf("v%0d_avg0", i),   avg_out0,   vecs[i].s3);
      check($sformatf("v%0d_min0", i),   min_out0,   vecs[i].s3);
      check($sformatf("v%0d_max0", i),   max_out0,   vecs[i].s3);
      tick();
      check($sformatf("v%0d_accepted", i), out_valid, 0);
    end

    // eoc held high 20 cycles counts as a single sample.
    b_in = 500;
    eoc  = 1'b1;
    repeat (20) tick();
    check("held_eoc_valid", out_valid, 0);
    eoc = 1'b0;
    tick();
    pulse(40); pulse(40);
    last_sample(40);
    check("held_frame_valid", out_valid, 1);
    check("held_frame_avg",   avg_out,   155);
    check("held_frame_min",   min_out,   40);
    check("held_frame_max",   max_out,   500);
    tick();

    // Overrun: second frame dropped while first is unaccepted.
    out_ready = 1'b0;
    pulse(200); pulse(200); pulse(200);
    last_sample(200);
    check("ovr_f1_valid",   out_valid, 1);
    check("ovr_f1_avg",     avg_out,   200);
    check("ovr_f1_overrun", overrun,   0);
    tick();
    pulse(300); pulse(300); pulse(300);
    last_sample(300);
    check("ovr_f2_valid",   out_valid, 1);
    check("ovr_f2_avg",     avg_out,   200);
    check("ovr_f2_overrun", overrun,   1);
    tick();
    pulse(400); pulse(400); pulse(400);
    check("ovr_hold_avg", avg_out, 200);
    b_in      = 400;
    eoc       = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ovr_f3_valid",   out_valid, 1);
    check("ovr_f3_avg",     avg_out,   400);
    check("ovr_f3_overrun", overrun,   1);
    eoc = 1'b0;
    tick();
    check("ovr_f3_accepted", out_valid, 0);

    // Enable drop discards the partial frame and clears overrun.
    pulse(10); pulse(10);
    enable = 1'b0;
    tick();
    check("dis_overrun", overrun, 0);
    enable = 1'b1;
    pulse(50); pulse(50); pulse(50);
    check("dis_pre_valid", out_valid, 0);
    last_sample(50);
    check("dis_valid", out_valid, 1);
    check("dis_avg",   avg_out,   50);
    check("dis_min",   min_out,   50);
    check("dis_max",   max_out,   50);
    check("dis_overrun_after", overrun, 0);
    tick();

    // Pending result survives an enable-low period until accepted.
    out_ready = 1'b0;
    pulse(60); pulse(60); pulse(60);
    last_sample(60);
    tick();
    enable = 1'b0;
    tick(); tick();
    check("pend_dis_valid", out_valid, 1);
    check("pend_dis_avg",   avg_out,   60);
    out_ready = 1'b1;
    tick();
    check("pend_dis_accepted", out_valid, 0);

    // Strobe on the same edge enable rises is the first sample.
    b_in   = 70;
    eoc    = 1'b1;
    enable = 1'b1;
    tick();
    eoc = 1'b0;
    tick();
    pulse(70); pulse(70);
    last_sample(70);
    check("en_rise_valid", out_valid, 1);
    check("en_rise_avg",   avg_out,   70);
    tick();

    // Reset with a pending result and a partial frame in progress.
    out_ready = 1'b0;
    pulse(80); pulse(80); pulse(80);
    last_sample(80);
    tick();
    pulse(5); pulse(5); pulse(5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid",   out_valid, 0);
    check("mid_rst_avg",     avg_out,   0);
    check("mid_rst_min",     min_out,   0);
    check("mid_rst_max",     max_out,   0);
    check("mid_rst_overrun", overrun,   0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    pulse(30); pulse(31); pulse(32);
    check("post_rst_pre_valid", out_valid, 0);
    last_sample(33);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_avg",   avg_out,   31);
    check("post_rst_min",   min_out,   30);
    check("post_rst_max",   max_out,   33);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_result_averager.md
ADC_RESULT_AVERAGER -- requirements
Module: adc_result_averager

Interface
REQ-001 Parameter DATA_W, default 10, conversion word width matching the ADC logic B output.
REQ-002 Parameter AVG_LOG2, default 2, log2 of samples per frame; legal range 0..4.
REQ-003 wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  1 = averaging active; 0 = discard partial frame, hold idle.
REQ-006 eoc  input  1  end-of-conversion level from the selected ADC logic; a sample is the 0->1 transition.
REQ-007 b_in  input  DATA_W  conversion result, stable while eoc is high.
REQ-008 out_ready  input  1  downstream accepts the result when out_valid and out_ready are both 1.
REQ-009 out_valid  output  1  a frame result is presented.
REQ-010 avg_out  output  DATA_W  frame mean, truncated.
REQ-011 min_out  output  DATA_W  smallest sample in the frame.
REQ-012 max_out  output  DATA_W  largest sample in the frame.
REQ-013 overrun  output  1  sticky: at least one completed frame was dropped.

Function
REQ-014 eoc SHALL be registered into eoc_q; sample strobe = eoc & ~eoc_q & enable, so eoc held high counts as a single sample.
REQ-015 On a strobe, b_in SHALL be captured at that clock edge into accumulator acc (width DATA_W+AVG_LOG2, never overflows), running min and running max.
REQ-016 First sample of a frame SHALL load acc, min and max directly with b_in; later samples add to acc and compare unsigned.
REQ-017 Sample counter (width AVG_LOG2+1) SHALL increment per strobe; frame completes on the strobe making it equal 2**AVG_LOG2.
REQ-018 On frame completion the result registers SHALL load avg = (acc + b_in) >> AVG_LOG2 with final min/max, and out_valid SHALL be 1 on the following cycle (1-cycle latency from the last capturing edge).
REQ-019 AVG_LOG2 = 0: every strobe is a frame; avg_out = min_out = max_out = b_in.
REQ-020 Accumulation state SHALL restart at count 0 the same edge a frame completes; back-to-back strobes lose no sample.
REQ-021 FSM states: IDLE (enable=0, counter cleared), ACCUM (collecting, no result pending), PEND (collecting, result pending on out_valid).
REQ-022 Transitions: IDLE->ACCUM when enable=1; ACCUM->PEND on frame completion; PEND->ACCUM on handshake with no simultaneous completion; any state->IDLE when enable=0.
REQ-023 avg_out/min_out/max_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Frame completion in PEND without handshake that cycle: new result SHALL be dropped, held result kept, overrun set to 1.
REQ-025 Frame completion in PEND with handshake that cycle: new result SHALL load, out_valid stays 1, overrun unchanged.
REQ-026 enable 1->0: partial frame SHALL be discarded; a pending result SHALL remain valid until accepted; overrun SHALL clear.
REQ-027 A strobe coinciding with enable 0->1 SHALL count as the frame's first sample.

Reset
REQ-028 With wb_rst_i=1 at a clock edge: state IDLE, counter 0, acc/min/max 0, eoc_q 0, out_valid 0, avg_out/min_out/max_out 0, overrun 0.
REQ-029 Reset asserted mid-frame or with a pending result SHALL discard both; no handshake occurs during reset.
REQ-030 eoc high at reset release SHALL not generate a strobe until it falls and rises again.

Structure
REQ-031 Shared package adc_pkg SHALL hold ADC_DATA_W=10, the FSM state enum (IDLE, ACCUM, PEND) and the AVG_LOG2 legal-range constant.
REQ-032 One sub-module adc_eoc_edge (registered rising-edge detector with enable gating) SHALL be instantiated; all else flat.

Verification
REQ-033 AVG_LOG2=2, out_ready=1, samples 100,104,108,112 -> one cycle after 4th strobe out_valid=1, avg_out=106, min_out=100, max_out=112.
REQ-034 AVG_LOG2=2, samples 1023 x4 -> avg_out=1023, no overflow; samples 0,1,1,1 -> avg_out=0 (truncation).
REQ-035 eoc held high 20 cycles with b_in=500 -> exactly one sample counted; frame incomplete, out_valid stays 0.
REQ-036 out_ready=0, two full frames (avg 200 then 300) -> avg_out stays 200, overrun=1; out_ready=1 with 3rd frame completing same cycle -> avg_out loads 3rd result, out_valid stays 1.
REQ-037 Two samples collected, enable dropped one cycle, then 4 samples of 50 -> avg_out=50 (partial frame discarded), overrun=0.
REQ-038 wb_rst_i pulsed after 3 samples with a result pending -> out_valid=0, all outputs 0; next 4 samples give a fresh correct frame.
